kmac_key_bytepad: RTL
=====================

Name: kmac_key_bytepad

Overview:
- Upstream stage of the KMAC padding/absorb path.
- On `start`, latches a key K and emits the byte stream bytepad(encode_string(K), RATE_BYTES) over a valid/ready interface.
- The consumer (the message/pad10*1 path into the Keccak absorber) receives exactly one or more full rate blocks of prefix before any message bytes.
- One byte per accepted beat; all encodings follow SP 800-185 left_encode/encode_string/bytepad.

Parameters:
- RATE_BYTES, 168, Keccak rate in bytes (168 = KMAC128, 136 = KMAC256); legal range 2..255.
- KEY_MAX_BYTES, 32, maximum key length in bytes; legal range 1..8191.
- KLEN_W, $clog2(KEY_MAX_BYTES+1), width of key_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin encoding; sampled only in IDLE
- key  in  KEY_MAX_BYTES*8  key; byte i = key[8*i +: 8], byte 0 emitted first
- key_len  in  KLEN_W  key length in bytes, 0..KEY_MAX_BYTES
- out_data  out  8  current output byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_last  out  1  marks the final byte of the padded prefix
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse in the cycle after the last byte is accepted
- err  out  1  one-cycle pulse when start is sampled with key_len > KEY_MAX_BYTES; no output follows

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0, err=0, state=IDLE, counters=0.
- start sampled in IDLE:
  - Latches key and key_len; computes L = 8*key_len (bit length).
  - Computes n = minimal bytes to hold L, with n ≥ 1.
  - Next cycle: state ENC_W, out_valid=1.
- start outside IDLE is ignored; key/key_len changes after start have no effect.
- States and emitted bytes:
  - ENC_W: emits 0x01, then RATE_BYTES (1 byte).
  - ENC_KLEN: emits n, then L big-endian in n bytes.
  - KEY: emits key bytes 0..key_len-1; skipped entirely when key_len=0.
  - ZPAD: emits 0x00 until the total byte count ≡ 0 mod RATE_BYTES; skipped if already aligned.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Advancing: a byte advances only on the handshake. While out_valid && !out_ready, out_data and out_last are held stable. out_valid is continuous from the first byte to the last byte; there are no bubbles.
- Byte counting: a pos counter runs modulo RATE_BYTES (width $clog2(RATE_BYTES)) and wraps to 0 on each block boundary. Total length is always a nonzero multiple of RATE_BYTES.
- out_last=1 only on the byte where pos == RATE_BYTES-1 AND all key bytes have been emitted.
- A start in the same cycle as done is ignored; the earliest restart is the next IDLE cycle.
- Reset mid-operation: immediate return to reset values; no partial last is signalled.

Optional Feature:
- Macro: KMAC_KEY_BYTEPAD_ABORT_EN.
- With the macro defined: adds input port `abort` (1 bit).
  - abort=1 in any non-IDLE state: next cycle state=IDLE, out_valid=0, busy=0, done=0, counters cleared.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE has no effect.
- Without the macro: no abort port; the sequence always runs to completion.

Decomposition:
- Package kmac_pkg:
  - state enum (IDLE, ENC_W, ENC_KLEN, KEY, ZPAD, DONE).
  - rate constants KMAC128_RATE=168, KMAC256_RATE=136.
  - function left_encode_len(L) returning n.
- Sub-module left_encode_byte (combinational): given value L, n and byte index j, returns the j-th byte of left_encode(L), where j=0 is n itself. It is used by ENC_KLEN; ENC_W uses the constants directly.

Test Plan:
- RATE=168, key_len=16, key bytes 0x40..0x4F, out_ready=1 → bytes 01 A8 01 80 40..4F, then 148×00; 168 beats total; out_last on beat 168; done on the next cycle.
- RATE=168, key_len=32 → 01 A8 02 01 00, then 32 key bytes, then 131×00; 168 beats.
- RATE=136, key_len=0 → 01 88 01 00, then 132×00; 136 beats; key state skipped.
- key_len=16 with random out_ready (≈50%) → identical byte sequence; out_data held stable during stalls; out_valid never drops mid-stream.
- key_len=33 with KEY_MAX_BYTES=32 → err pulse, busy stays 0, no out_valid; with ABORT_EN, abort at beat 10 → IDLE next cycle, no done, and a following start produces the full correct stream.
- rst_n asserted at beat 50 → all outputs 0 immediately; a start after reset produces a correct fresh sequence.

Source files
------------

// File: rtl/kmac_pkg.sv
// Shared types and helpers for the KMAC key prefix path.
// SP 800-185 left_encode length helper and Keccak rate constants.
package kmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENC_W,
        ENC_KLEN,
        KEY,
        ZPAD,
        DONE
    } kstate_e;

    localparam int KMAC128_RATE = 168;
    localparam int KMAC256_RATE = 136;

    // Minimal byte count holding l, never below one.
    function automatic logic [7:0] left_encode_len(input logic [31:0] l);
        logic [7:0] n;
        n = 8'd1;
        for (int i = 1; i < 4; i++) begin
            if ((l >> (8 * i)) != 32'd0) begin
                n = 8'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/left_encode_byte.sv
// One byte of left_encode(val): j=0 gives n, j=1..n give val big-endian.
// Purely combinational.
module left_encode_byte #(
    parameter int VW = 16
) (
    input  logic [VW-1:0] val_i,
    input  logic [7:0]    n_i,
    input  logic [7:0]    j_i,
    output logic [7:0]    byte_o
);

    localparam int NB = (VW + 7) / 8;
    localparam int PB = NB * 8;

    logic [PB-1:0] val_pad;
    logic [7:0]    rsel;

    assign val_pad = PB'(val_i);
    assign rsel    = n_i - j_i;

    always_comb begin
        byte_o = 8'h00;
        if (j_i == 8'd0) begin
            byte_o = n_i;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (rsel == 8'(k)) begin
                    byte_o = val_pad[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/kmac_key_bytepad.sv
// Streams bytepad(encode_string(K), RATE_BYTES), one byte per handshake.
// Optional abort input enabled by KMAC_KEY_BYTEPAD_ABORT_EN.
module kmac_key_bytepad
    import kmac_pkg::*;
#(
    parameter int RATE_BYTES    = KMAC128_RATE,
    parameter int KEY_MAX_BYTES = 32,
    parameter int KLEN_W        = $clog2(KEY_MAX_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KEY_MAX_BYTES*8-1:0] key,
    input  logic [KLEN_W-1:0]          key_len,
    input  logic                       out_ready,
`ifdef KMAC_KEY_BYTEPAD_ABORT_EN
    input  logic                       abort,
`endif
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int PW = $clog2(RATE_BYTES);
    localparam int LW = KLEN_W + 3;
    localparam int IW = (KLEN_W > 8) ? KLEN_W : 8;

    localparam logic [PW-1:0]     PLAST = PW'(RATE_BYTES - 1);
    localparam logic [KLEN_W-1:0] KMAX  = KLEN_W'(KEY_MAX_BYTES);

    kstate_e                  state_q, state_d;
    logic [PW-1:0]            pos_q, pos_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [KEY_MAX_BYTES*8-1:0] key_q;
    logic [KLEN_W-1:0]        klen_q;
    logic [LW-1:0]            lbits_q;
    logic [7:0]               n_q;
    logic                     err_q, err_d;

    logic          abort_w;
    logic          load;
    logic          fire;
    logic [PW-1:0] pos_inc;
    logic          key_end;
    logic          klen_end;
    logic [7:0]    enc_byte;

`ifdef KMAC_KEY_BYTEPAD_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign load     = (state_q == IDLE) && start && (key_len <= KMAX);
    assign err_d    = (state_q == IDLE) && start && (key_len > KMAX);
    assign fire     = out_valid && out_ready;
    assign pos_inc  = (pos_q == PLAST) ? '0 : pos_q + PW'(1);
    assign key_end  = (idx_q == IW'(klen_q) - IW'(1));
    assign klen_end = (idx_q == IW'(n_q));

    left_encode_byte #(
        .VW(LW)
    ) u_lenc (
        .val_i (lbits_q),
        .n_i   (n_q),
        .j_i   (idx_q[7:0]),
        .byte_o(enc_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            idx_q   <= '0;
            key_q   <= '0;
            klen_q  <= '0;
            lbits_q <= '0;
            n_q     <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (load) begin
                key_q   <= key;
                klen_q  <= key_len;
                lbits_q <= {key_len, 3'b000};
                n_q     <= left_encode_len(32'({key_len, 3'b000}));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = ENC_W;
                    pos_d   = '0;
                    idx_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                if (fire) begin
                    pos_d = pos_inc;
                    idx_d = idx_q + IW'(1);
                    unique case (state_q)
                        ENC_W: begin
                            if (idx_q == IW'(1)) begin
                                state_d = ENC_KLEN;
                                idx_d   = '0;
                            end
                        end
                        ENC_KLEN: begin
                            if (klen_end) begin
                                idx_d = '0;
                                if (klen_q != '0) begin
                                    state_d = KEY;
                                end else if (pos_inc == '0) begin
                                    state_d = DONE;
                                end else begin
                                    state_d = ZPAD;
                                end
                            end
                        end
                        KEY: begin
                            if (key_end) begin
                                idx_d   = '0;
                                state_d = (pos_inc == '0) ? DONE : ZPAD;
                            end
                        end
                        ZPAD: begin
                            idx_d = '0;
                            if (pos_q == PLAST) begin
                                state_d = DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        // Abort wins over any handshake in flight.
        if (abort_w && state_q != IDLE) begin
            state_d = IDLE;
            pos_d   = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        out_data  = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = (state_q == DONE);
        err       = err_q;
        unique case (state_q)
            ENC_W: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = (idx_q == '0) ? 8'h01 : 8'(RATE_BYTES);
            end
            ENC_KLEN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = enc_byte;
                out_last  = (pos_q == PLAST) && klen_end && (klen_q == '0);
            end
            KEY: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = key_q[{idx_q, 3'b000} +: 8];
                out_last  = (pos_q == PLAST) && key_end;
            end
            ZPAD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (pos_q == PLAST);
            end
            default: ;
        endcase
    end

endmodule
